// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_DEF_DATA_W = 8;
  localparam int FIFO_DEF_DEPTH  = 16;

  // Ceiling log2; constant-foldable so it can size ports and pointers.
  function automatic int fifo_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port storage array with registered read; a same-address
// write and read in one cycle returns the old contents.
module sync_fifo_param_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointer/count logic, accept rules and
// registered status flags around a dual-port storage array.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DEF_DATA_W,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic                   rd,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      WRITE_DATA,
  output logic [DATA_W-1:0]      READ_DATA,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic                   ALMOST_FULL,
  output logic                   ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW
);

  localparam int ADDR_W = fifo_clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  // Request semantics: wr/rd are requests sampled every edge. A read is
  // accepted whenever the FIFO holds data; a write whenever there is room
  // or a read in the same cycle frees a slot. Rejected requests leave the
  // state untouched and raise OVERFLOW/UNDERFLOW for exactly one cycle.
  logic             rd_ok, wr_ok;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] next_wr_ptr, next_rd_ptr, next_count;

  assign rd_ok = rd & ~EMPTY;
  assign wr_ok = wr & (~FULL | rd_ok);

  always_comb begin
    next_wr_ptr = wr_ptr;
    next_rd_ptr = rd_ptr;
    if (flush) begin
      next_wr_ptr = '0;
      next_rd_ptr = '0;
    end else begin
      next_wr_ptr = wr_ptr + {{ADDR_W{1'b0}}, wr_ok};
      next_rd_ptr = rd_ptr + {{ADDR_W{1'b0}}, rd_ok};
    end
    next_count = next_wr_ptr - next_rd_ptr;
  end

  // Flags are derived from the next-state count so all of them move together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      COUNT        <= '0;
      EMPTY        <= 1'b1;
      ALMOST_EMPTY <= 1'b1;
      FULL         <= 1'b0;
      ALMOST_FULL  <= 1'b0;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      wr_ptr       <= next_wr_ptr;
      rd_ptr       <= next_rd_ptr;
      COUNT        <= next_count;
      EMPTY        <= (next_count == '0);
      FULL         <= (next_count == PTR_W'(DEPTH));
      ALMOST_FULL  <= (next_count >= PTR_W'(AF_LEVEL));
      ALMOST_EMPTY <= (next_count <= PTR_W'(AE_LEVEL));
      OVERFLOW     <= ~flush & wr & ~wr_ok;
      UNDERFLOW    <= ~flush & rd & ~rd_ok;
    end
  end

  sync_fifo_param_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok & ~flush & rst),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (WRITE_DATA),
    .re    (rd_ok & ~flush),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (READ_DATA)
  );

endmodule
